// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes, LSU FSM states and an alignment helper.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE,
    LSU_WAIT
  } lsu_state_t;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return off[0];
      LDST_W:          return off != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane formatting: byte enables, store-data replication, load extract/extend.
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wd,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    be = 4'b0000;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
  end

  always_comb begin
    wd_rep = wd;
    case (size)
      LDST_B, LDST_BU: wd_rep = {4{wd[7:0]}};
      LDST_H, LDST_HU: wd_rep = {2{wd[15:0]}};
      default:         wd_rep = wd;
    endcase
  end

  // Stores never return data, so the load path is forced to zero for them.
  always_comb begin
    rd = 32'd0;
    if (!we) begin
      case (size)
        LDST_B:  rd = {{24{byte_sel[7]}}, byte_sel};
        LDST_BU: rd = {24'd0, byte_sel};
        LDST_H:  rd = {{16{half_sel[15]}}, half_sel};
        LDST_HU: rd = {16'd0, half_sel};
        LDST_W:  rd = raw;
        default: rd = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/lsu_riscv.sv
// Load-store unit: issue/wait FSM with timeout between core and data memory.
// Optional misalignment trap enabled by `LSU_MISALIGN_CHECK_EN.
module lsu_riscv
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  lsu_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  logic        misaligned;
  logic        timeout;
  logic        req, stall, fault, rd_kill;
  logic [3:0]  be_fmt;
  logic [31:0] wd_fmt, rd_fmt;

  lsu_data_align u_align (
    .size   (core_size_i),
    .off    (core_addr_i[1:0]),
    .we     (core_we_i),
    .wd     (core_wd_i),
    .raw    (mem_rd_i),
    .be     (be_fmt),
    .wd_rep (wd_fmt),
    .rd     (rd_fmt)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = lsu_misaligned(core_size_i, core_addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Fires on the last permitted WAIT cycle; a ready in that same cycle takes priority.
  assign timeout = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT - 1)) && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= LSU_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req          = 1'b0;
    stall        = 1'b0;
    fault        = 1'b0;
    rd_kill      = 1'b0;
    case (state)
      LSU_IDLE: begin
        wait_cnt_nxt = '0;
        if (core_req_i) begin
          if (misaligned) begin
            fault = 1'b1;
          end else begin
            req       = 1'b1;
            stall     = 1'b1;
            state_nxt = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        req = 1'b1;
        if (mem_ready_i) begin
          state_nxt    = LSU_IDLE;
          wait_cnt_nxt = '0;
        end else if (timeout) begin
          fault        = 1'b1;
          rd_kill      = 1'b1;
          state_nxt    = LSU_IDLE;
          wait_cnt_nxt = '0;
        end else begin
          stall        = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = LSU_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Reset gates the outputs directly so an in-flight access vanishes immediately.
  assign mem_req_o    = rst_ni & req;
  assign mem_we_o     = rst_ni & req & core_we_i;
  assign core_stall_o = rst_ni & stall;
  assign core_fault_o = rst_ni & fault;
  assign mem_be_o     = rst_ni ? be_fmt : 4'b0000;
  assign core_rd_o    = (rst_ni && !rd_kill) ? rd_fmt : 32'd0;
  assign mem_addr_o   = core_addr_i;
  assign mem_wd_o     = wd_fmt;

endmodule

// File: tb/tb_lsu_riscv.sv
// Bench for lsu_riscv: directed cases plus randomized accesses against a reference model.
module tb_lsu_riscv;
  import riscv_pkg::*;

  localparam int unsigned MAXW = 4;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0, core_wd = 32'd0;
  logic [31:0] core_rd;
  logic        core_stall, core_fault;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_riscv #(.MAX_WAIT(MAXW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .core_fault_o (core_fault),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_byte(input logic [2:0] s);
    return s == LDST_B || s == LDST_BU;
  endfunction

  function automatic bit is_half(input logic [2:0] s);
    return s == LDST_H || s == LDST_HU;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] s, input int off);
    bit m;
    m = (is_half(s) && (off % 2) == 1) || (s == LDST_W && off != 0);
    return m && CHK_EN;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] s, input int off);
    if (is_byte(s)) return 4'(1 << off);
    if (is_half(s)) return (off >= 2) ? 4'hC : 4'h3;
    if (s == LDST_W) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] wd);
    if (is_byte(s)) return (wd % 256) * 32'h0101_0101;
    if (is_half(s)) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [2:0] s, input int off,
                                          input logic [31:0] w, input bit we);
    logic [31:0] b, h;
    if (we) return 32'd0;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (s)
      LDST_B:  return (b >= 128) ? b - 32'd256 : b;
      LDST_BU: return b;
      LDST_H:  return (h >= 32768) ? h - 32'd65536 : h;
      LDST_HU: return h;
      LDST_W:  return w;
      default: return 32'd0;
    endcase
  endfunction

  // One access: issue cycle, then WAIT cycles with ready raised after 'dly' of them.
  // dly >= MAXW means the memory never answers.
  task automatic do_txn(input string tag, input bit we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input int dly, input bit issue_rdy);
    int off;
    off = int'(addr % 4);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_rd = word; mem_ready = issue_rdy;
    @(negedge clk);
    if (ref_misaligned(size, off)) begin
      check({tag, ".mis_fault"}, 32'(core_fault), 32'd1);
      check({tag, ".mis_stall"}, 32'(core_stall), 32'd0);
      check({tag, ".mis_req"},   32'(mem_req),    32'd0);
      return;
    end
    check({tag, ".iss_req"},   32'(mem_req),    32'd1);
    check({tag, ".iss_stall"}, 32'(core_stall), 32'd1);
    check({tag, ".iss_fault"}, 32'(core_fault), 32'd0);
    check({tag, ".iss_we"},    32'(mem_we),     32'(we));
    check({tag, ".be"},        32'(mem_be),     32'(ref_be(size, off)));
    check({tag, ".addr"},      mem_addr,        addr);
    check({tag, ".wd"},        mem_wd,          ref_wd(size, wd));
    for (int k = 0; k < int'(MAXW); k++) begin
      @(posedge clk); #1;
      mem_ready = (k == dly);
      @(negedge clk);
      if (k == dly) begin
        check({tag, ".done_stall"}, 32'(core_stall), 32'd0);
        check({tag, ".done_fault"}, 32'(core_fault), 32'd0);
        check({tag, ".rd"},         core_rd,         ref_rd(size, off, word, we));
        break;
      end else if (k == int'(MAXW) - 1) begin
        check({tag, ".to_fault"}, 32'(core_fault), 32'd1);
        check({tag, ".to_stall"}, 32'(core_stall), 32'd0);
        check({tag, ".to_rd"},    core_rd,         32'd0);
      end else begin
        check({tag, ".w_stall"}, 32'(core_stall), 32'd1);
        check({tag, ".w_req"},   32'(mem_req),    32'd1);
        check({tag, ".w_fault"}, 32'(core_fault), 32'd0);
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    core_req = 1'b0; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, ".idle_req"},   32'(mem_req),    32'd0);
    check({tag, ".idle_stall"}, 32'(core_stall), 32'd0);
    check({tag, ".idle_fault"}, 32'(core_fault), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},   32'(mem_req),    32'd0);
    check({tag, ".we"},    32'(mem_we),     32'd0);
    check({tag, ".stall"}, 32'(core_stall), 32'd0);
    check({tag, ".fault"}, 32'(core_fault), 32'd0);
    check({tag, ".be"},    32'(mem_be),     32'd0);
    check({tag, ".rd"},    core_rd,         32'd0);
  endtask

  initial begin
    logic [2:0]  size;
    logic [31:0] addr;
    bit          we;

    // Requests held during reset must not leak out.
    core_req = 1'b1; core_we = 1'b1; core_size = LDST_W; mem_rd = 32'hFFFF_FFFF;
    #3;
    check_all_zero("rst");
    @(posedge clk); #1;
    core_req = 1'b0;
    rst_n = 1'b1;

    do_txn("lw",   1'b0, LDST_W,  32'h104, 32'd0,         32'hDEAD_BEEF, 0, 1'b0);
    do_txn("lb",   1'b0, LDST_B,  32'h103, 32'd0,         32'h8000_0000, 0, 1'b0);
    do_txn("lbu",  1'b0, LDST_BU, 32'h103, 32'd0,         32'h8000_0000, 0, 1'b0);
    do_txn("sh",   1'b1, LDST_H,  32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 1'b0);
    idle_cycle("gap");
    do_txn("lw_slow", 1'b0, LDST_W, 32'h108, 32'd0, 32'hCAFE_F00D, 3, 1'b1);
    do_txn("lw_to",   1'b0, LDST_W, 32'h10C, 32'd0, 32'h1111_2222, 4, 1'b0);
    idle_cycle("after_to");
    do_txn("lw_mis",  1'b0, LDST_W, 32'h102, 32'd0, 32'h0BAD_CAFE, 0, 1'b0);
    do_txn("lh_ill",  1'b0, 3'd6,   32'h100, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);

    // Reset in the middle of a WAIT drops everything at once.
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_size = LDST_W; core_addr = 32'h300;
    core_wd = 32'hA5A5_A5A5; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    @(posedge clk); #1;
    core_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.stall", 32'(core_stall), 32'd0);
    check("post_rst.req",   32'(mem_req),    32'd0);
    do_txn("post_rst", 1'b0, LDST_HU, 32'h302, 32'd0, 32'h8001_7FFF, 1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = 3'($urandom_range(0, 7));
      addr = $urandom;
      do_txn("rnd", we, size, addr, $urandom, $urandom,
             int'($urandom_range(0, MAXW)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
